// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage: slot A waits for the register file read,
// slot B is the output register presented to EX over valid/ready.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   rf_out1,
  input  logic [XLEN-1:0]   rf_out2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic accept, move;

  logic                        a_valid_q, a_valid_d, a_fresh_q, a_fresh_d;
  logic [1:0]                  a_byp_q, a_byp_d;
  logic [1:0][REG_AW-1:0]      a_rs_q, a_rs_d;
  logic [1:0][XLEN-1:0]        a_op_q, a_op_d;
  logic [REG_AW-1:0]           a_rd_q, a_rd_d;
  logic [XLEN-1:0]             a_imm_q, a_imm_d, a_pc_q, a_pc_d;
  logic [CTRL_W-1:0]           a_ctrl_q, a_ctrl_d;

  logic                        b_valid_q, b_valid_d;
  logic [1:0][XLEN-1:0]        b_op_q, b_op_d;
  logic [REG_AW-1:0]           b_rd_q, b_rd_d;
  logic [XLEN-1:0]             b_imm_q, b_imm_d, b_pc_q, b_pc_d;
  logic [CTRL_W-1:0]           b_ctrl_q, b_ctrl_d;

  logic [1:0][REG_AW-1:0]      in_rs;
  logic [1:0][XLEN-1:0]        rf_out, res_op, acc_op;
  logic [1:0]                  same_edge_byp;

  assign in_rs  = {in_rs2, in_rs1};
  assign rf_out = {rf_out2, rf_out1};

  assign move     = a_valid_q & (~b_valid_q | out_ready);
  assign in_ready = ~reset & ~flush & (~a_valid_q | move);
  assign accept   = in_valid & in_ready;

  // The rf returns the pre-write value when a write lands on the read edge,
  // so such sources are captured from wb_data directly.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign same_edge_byp[gi] = wb_we & (wb_rd == in_rs[gi]) & (in_rs[gi] != '0);
      assign acc_op[gi]        = same_edge_byp[gi] ? wb_data : '0;
      assign res_op[gi] = (a_rs_q[gi] == '0)                ? '0 :
                          (wb_we && wb_rd == a_rs_q[gi])    ? wb_data :
                          (a_fresh_q && !a_byp_q[gi])       ? rf_out[gi] :
                                                              a_op_q[gi];
    end
  endgenerate

  always_comb begin
    a_valid_d = a_valid_q;
    a_fresh_d = a_fresh_q;
    a_byp_d   = a_byp_q;
    a_rs_d    = a_rs_q;
    a_op_d    = a_op_q;
    a_rd_d    = a_rd_q;
    a_imm_d   = a_imm_q;
    a_pc_d    = a_pc_q;
    a_ctrl_d  = a_ctrl_q;
    b_valid_d = b_valid_q;
    b_op_d    = b_op_q;
    b_rd_d    = b_rd_q;
    b_imm_d   = b_imm_q;
    b_pc_d    = b_pc_q;
    b_ctrl_d  = b_ctrl_q;

    if (accept) begin
      a_valid_d = 1'b1;
      a_fresh_d = 1'b1;
      a_byp_d   = same_edge_byp;
      a_op_d    = acc_op;
      a_rs_d    = in_rs;
      a_rd_d    = in_rd;
      a_imm_d   = in_imm;
      a_pc_d    = in_pc;
      a_ctrl_d  = in_ctrl;
    end else if (move) begin
      a_valid_d = 1'b0;
      a_fresh_d = 1'b0;
    end else if (a_valid_q) begin
      // rf outputs change next edge; keep our own resolved copy.
      a_op_d    = res_op;
      a_byp_d   = 2'b11;
      a_fresh_d = 1'b0;
    end

    if (move) begin
      b_valid_d = 1'b1;
      b_op_d    = res_op;
      b_rd_d    = a_rd_q;
      b_imm_d   = a_imm_q;
      b_pc_d    = a_pc_q;
      b_ctrl_d  = a_ctrl_q;
    end else if (b_valid_q && out_ready) begin
      b_valid_d = 1'b0;
    end

    if (flush) begin
      a_valid_d = 1'b0;
      a_fresh_d = 1'b0;
      b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_fresh_q <= 1'b0;
      a_byp_q   <= '0;
      a_rs_q    <= '0;
      a_op_q    <= '0;
      a_rd_q    <= '0;
      a_imm_q   <= '0;
      a_pc_q    <= '0;
      a_ctrl_q  <= '0;
      b_valid_q <= 1'b0;
      b_op_q    <= '0;
      b_rd_q    <= '0;
      b_imm_q   <= '0;
      b_pc_q    <= '0;
      b_ctrl_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_fresh_q <= a_fresh_d;
      a_byp_q   <= a_byp_d;
      a_rs_q    <= a_rs_d;
      a_op_q    <= a_op_d;
      a_rd_q    <= a_rd_d;
      a_imm_q   <= a_imm_d;
      a_pc_q    <= a_pc_d;
      a_ctrl_q  <= a_ctrl_d;
      b_valid_q <= b_valid_d;
      b_op_q    <= b_op_d;
      b_rd_q    <= b_rd_d;
      b_imm_q   <= b_imm_d;
      b_pc_q    <= b_pc_d;
      b_ctrl_q  <= b_ctrl_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_op1   = b_op_q[0];
  assign out_op2   = b_op_q[1];
  assign out_rd    = b_rd_q;
  assign out_imm   = b_imm_q;
  assign out_pc    = b_pc_q;
  assign out_ctrl  = b_ctrl_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with a small register file model
// that has registered reads and read-old-on-write behaviour.
module tb_id_ex_operand_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [31:0] in_imm = '0, in_pc = '0;
  logic [15:0] in_ctrl = '0;
  logic [31:0] rf_out1 = '0, rf_out2 = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_op1, out_op2, out_imm, out_pc;
  logic [4:0]  out_rd;
  logic [15:0] out_ctrl;

  logic [31:0] rf [32];
  int n_cmp = 0;
  int n_bad = 0;

  id_ex_operand_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .rf_out1(rf_out1), .rf_out2(rf_out2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc), .out_ctrl(out_ctrl)
  );

  always #5 clock = ~clock;

  // Register file: reads sample the pre-write contents on the same edge.
  always @(posedge clock) begin
    rf_out1 <= (in_rs1 == 5'd0) ? 32'd0 : rf[in_rs1];
    rf_out2 <= (in_rs2 == 5'd0) ? 32'd0 : rf[in_rs2];
    if (wb_we && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic [31:0] pc);
    in_valid = v;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_pc    = pc;
    in_imm   = pc ^ 32'h0000_00FF;
    in_ctrl  = pc[15:0];
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = d;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [4:0] rd, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_op1"}, out_op1, op1);
    chk({tag, "_op2"}, out_op2, op2);
    chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_imm"}, out_imm, pc ^ 32'h0000_00FF);
    chk({tag, "_ctrl"}, {16'd0, out_ctrl}, {16'd0, pc[15:0]});
    $display("txn %s: op1=%h op2=%h rd=%0d pc=%h", tag, out_op1, out_op2, out_rd, out_pc);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;

    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_op1", out_op1, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Preload register file through the writeback port
    wb(1, 5, 32'h11);   tick();
    wb(1, 3, 32'h300);  tick();
    wb(1, 4, 32'h400);  tick();
    wb(1, 6, 32'h600);  tick();
    wb(1, 7, 32'h1234); tick();
    wb(1, 9, 32'h33);   tick();
    wb(0, 0, 32'h0);

    // Four back-to-back instructions, full rate
    out_ready = 1'b1;
    drv(1, 5, 0, 1, 32'h1000); tick();
    chk("b2b_lat_valid", {31'd0, out_valid}, 32'd0);
    drv(1, 3, 4, 2, 32'h1004);
    chk("b2b_rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("b2b_i0", 32'h11, 32'h0, 5'd1, 32'h1000);
    drv(1, 6, 5, 3, 32'h1008);
    chk("b2b_rdy2", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("b2b_i1", 32'h300, 32'h400, 5'd2, 32'h1004);
    drv(1, 4, 6, 4, 32'h100C);
    chk("b2b_rdy3", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("b2b_i2", 32'h600, 32'h11, 5'd3, 32'h1008);
    drv(0, 0, 0, 0, 32'h0); tick();
    chk_out("b2b_i3", 32'h400, 32'h600, 5'd4, 32'h100C);
    tick();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // Same-edge writeback on accept: rf returns stale 0x1234
    drv(1, 7, 0, 3, 32'h1100);
    wb(1, 7, 32'hABCD);
    tick();
    wb(0, 0, 32'h0);
    drv(0, 0, 0, 0, 32'h0);
    tick();
    chk_out("same_edge", 32'hABCD, 32'h0, 5'd3, 32'h1100);
    tick();

    // Stall: B holds Ia, A holds Ib waiting; x9 written while Ib sits in A
    out_ready = 1'b0;
    drv(1, 5, 0, 6, 32'h2000); tick();
    drv(1, 0, 9, 7, 32'h2004);
    chk("stall_rdy_move", {31'd0, in_ready}, 32'd1);
    tick();
    drv(0, 0, 0, 0, 32'h0);
    chk("stall_rdy_full1", {31'd0, in_ready}, 32'd0);
    chk_out("stall_b1", 32'h11, 32'h0, 5'd6, 32'h2000);
    tick();
    wb(1, 9, 32'h55);
    #1;
    chk("stall_rdy_full2", {31'd0, in_ready}, 32'd0);
    chk_out("stall_b2", 32'h11, 32'h0, 5'd6, 32'h2000);
    tick();
    wb(0, 0, 32'h0);
    chk_out("stall_b3", 32'h11, 32'h0, 5'd6, 32'h2000);
    out_ready = 1'b1;
    tick();
    chk_out("stall_ib", 32'h0, 32'h55, 5'd7, 32'h2004);
    tick();
    chk("stall_drain", {31'd0, out_valid}, 32'd0);

    // Writeback to x0 must never reach an rs==0 operand
    drv(1, 0, 5, 8, 32'h3000);
    wb(1, 0, 32'hFFFF_FFFF);
    tick();
    drv(0, 0, 0, 0, 32'h0);
    tick();
    wb(0, 0, 32'h0);
    chk_out("x0_write", 32'h0, 32'h11, 5'd8, 32'h3000);
    tick();

    // Flush with A and B full and a new instruction offered
    out_ready = 1'b0;
    drv(1, 3, 0, 10, 32'h4000); tick();
    drv(1, 4, 0, 11, 32'h4004); tick();
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    drv(1, 6, 0, 12, 32'h4008);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    drv(0, 0, 0, 0, 32'h0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_emerge", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset while B holds an instruction
    out_ready = 1'b0;
    drv(1, 5, 0, 13, 32'h5000); tick();
    drv(0, 0, 0, 0, 32'h0); tick();
    chk_out("arst_pre", 32'h11, 32'h0, 5'd13, 32'h5000);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_op1", out_op1, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    drv(1, 3, 4, 14, 32'h6000);
    chk("arst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_rel_valid", {31'd0, out_valid}, 32'd0);
    tick();
    drv(0, 0, 0, 0, 32'h0);
    chk("arst_lat_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_out("arst_new", 32'h300, 32'h400, 5'd14, 32'h6000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
